// File: rtl/pc_sequencer_if.sv
// Command/stack bus between the instruction decoder, the PC sequencer and the return-address stack.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);

  logic              en;
  logic              jump;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] pc;
  logic              stack_push;
  logic              stack_pop;
  logic [ADDR_W-1:0] stack_wdata;
  logic              busy;
  logic              fault;

  // Decoder/stack side: issues commands, supplies the stack top, observes PC and strobes
  modport master (
    output en, jump, call, ret, target, stack_top,
    input  pc, stack_push, stack_pop, stack_wdata, busy, fault
  );

  // Sequencer side
  modport slave (
    input  en, jump, call, ret, target, stack_top,
    output pc, stack_push, stack_pop, stack_wdata, busy, fault
  );

endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment / JUMP / CALL / RETURN, driving the return-address stack.
// Optional macro STACK_GUARD_EN adds a depth counter with sticky over/underflow fault.
// Updates on posedge nclk; the stack samples the registered strobes on negedge nclk.
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned RESET_VEC   = 0
) (
  input  logic          nclk,
  input  logic          nreset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_LOAD = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic              push_q, push_d;
  logic              pop_q, pop_d;
  logic              busy_q, busy_d;
  logic              can_push_c;
  logic              can_pop_c;

  // Reject a stack depth that cannot hold a single return address
  if (STACK_DEPTH < 1) begin : g_depth_check
    $error("pc_sequencer: STACK_DEPTH must be at least 1");
  end

`ifdef STACK_GUARD_EN
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               fault_q, fault_d;

  assign can_push_c = (depth_q != DEPTH_W'(STACK_DEPTH));
  assign can_pop_c  = (depth_q != '0);
  assign bus.fault  = fault_q;
`else
  // Unguarded: the stack pointer wraps silently, so every push/pop is issued
  assign can_push_c = 1'b1;
  assign can_pop_c  = 1'b1;
  assign bus.fault  = 1'b0;
`endif

  assign bus.pc          = pc_q;
  assign bus.stack_push  = push_q;
  assign bus.stack_pop   = pop_q;
  assign bus.stack_wdata = wdata_q;
  assign bus.busy        = busy_q;

  // Next-state and next-output decode; strobes default low so they last one cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wdata_d = wdata_q;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    busy_d  = 1'b0;
`ifdef STACK_GUARD_EN
    depth_d = depth_q;
    fault_d = fault_q;
`endif
    case (state_q)
      RUN: begin
        if (bus.en) begin
          if (bus.ret) begin
            if (can_pop_c) begin
              pop_d   = 1'b1;
              busy_d  = 1'b1;
              state_d = RET_LOAD;
`ifdef STACK_GUARD_EN
              depth_d = depth_q - DEPTH_W'(1);
`endif
            end else begin
              state_d = FAULT;
`ifdef STACK_GUARD_EN
              fault_d = 1'b1;
`endif
            end
          end else if (bus.call) begin
            if (can_push_c) begin
              pc_d    = bus.target;
              wdata_d = pc_q + ADDR_W'(1);
              push_d  = 1'b1;
`ifdef STACK_GUARD_EN
              depth_d = depth_q + DEPTH_W'(1);
`endif
            end else begin
              state_d = FAULT;
`ifdef STACK_GUARD_EN
              fault_d = 1'b1;
`endif
            end
          end else if (bus.jump) begin
            pc_d = bus.target;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      RET_LOAD: begin
        // Stack pointer moved on the intervening negedge; top now holds the return address
        pc_d    = bus.stack_top;
        state_d = RUN;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge nclk) begin
    if (!nreset) begin
      state_q <= RUN;
      pc_q    <= ADDR_W'(RESET_VEC);
      wdata_q <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wdata_q <= wdata_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
    end
  end

`ifdef STACK_GUARD_EN
  // Guard depth counter and sticky fault flag
  always_ff @(posedge nclk) begin
    if (!nreset) begin
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, guard/reset corner sequences, randomized run
// against a queue-based return-stack model. Honours STACK_GUARD_EN like the design.
module tb_pc_sequencer;

  logic nclk;
  logic nreset;
  int   n_checks;
  int   n_fail;

  pc_sequencer_if #(.ADDR_W(8)) bus ();

  pc_sequencer #(
    .ADDR_W      (8),
    .STACK_DEPTH (16),
    .RESET_VEC   (0)
  ) dut (
    .nclk   (nclk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial nclk = 1'b0;
  always #5 nclk = ~nclk;

  // Return-address stack: ops on negedge, reset on posedge, top = entry at pointer
  logic [7:0] stk_mem [16];
  logic [3:0] stk_sp;

  assign bus.stack_top = stk_mem[stk_sp];

  always @(nclk) begin
    if (nclk) begin
      if (!nreset) stk_sp <= 4'd0;
    end else begin
      if (bus.stack_push) begin
        stk_mem[stk_sp] <= bus.stack_wdata;
        stk_sp          <= stk_sp + 4'd1;
      end else if (bus.stack_pop) begin
        stk_sp <= stk_sp - 4'd1;
      end
    end
  end

  typedef struct {
    logic       en;
    logic       jump;
    logic       call;
    logic       ret;
    logic [7:0] target;
    logic [7:0] pc;
    logic       push;
    logic       pop;
    logic       busy;
    logic [7:0] wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic j, input logic c, input logic r,
                              input logic [7:0] t, input logic [7:0] p, input logic pu,
                              input logic po, input logic b, input logic [7:0] wd);
    vec_t v;
    v.en = e; v.jump = j; v.call = c; v.ret = r; v.target = t;
    v.pc = p; v.push = pu; v.pop = po; v.busy = b; v.wdata = wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] p, input logic pu,
                            input logic po, input logic b, input logic f);
    check({tag, " pc"},   32'(bus.pc),         32'(p));
    check({tag, " push"}, 32'(bus.stack_push), 32'(pu));
    check({tag, " pop"},  32'(bus.stack_pop),  32'(po));
    check({tag, " busy"}, 32'(bus.busy),       32'(b));
    check({tag, " fault"}, 32'(bus.fault),     32'(f));
  endtask

  // Apply one cycle of inputs from a negedge, sample 1 time unit after the posedge
  task automatic step(input logic e, input logic j, input logic c, input logic r,
                      input logic [7:0] t);
    @(negedge nclk);
    bus.en = e; bus.jump = j; bus.call = c; bus.ret = r; bus.target = t;
    @(posedge nclk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge nclk);
    nreset = 1'b0;
    bus.en = 1'b0; bus.jump = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.target = 8'h00;
    @(posedge nclk);
    #1;
    nreset = 1'b1;
  endtask

  // Behavioural model state for the random run
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_returning;
  logic [7:0] m_ret_addr;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nreset   = 1'b0;
    bus.en = 1'b0; bus.jump = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.target = 8'h00;

    // Reset state
    do_reset();
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset wdata", 32'(bus.stack_wdata), 32'h0);

    // Directed table: count, call/return, priority, wrap and hold
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h04, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h05, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 0, 8'h40, 8'h40, 1, 0, 0, 8'h06));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h41, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h42, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h43, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'h43, 0, 1, 1, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 8'h99, 8'h06, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 0, 8'h20, 8'h20, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 0, 8'h10, 8'h10, 1, 0, 0, 8'h21));
    vecs.push_back(mk(1, 1, 1, 1, 8'h77, 8'h10, 0, 1, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h21, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 0, 8'hFE, 8'hFE, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 0, 8'h55, 8'h00, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 8'h66, 8'h00, 0, 0, 0, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].jump, vecs[i].call, vecs[i].ret, vecs[i].target);
      check_outs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].push, vecs[i].pop,
                 vecs[i].busy, 1'b0);
      if (vecs[i].push)
        check($sformatf("vec%0d wdata", i), 32'(bus.stack_wdata), 32'(vecs[i].wdata));
    end

    // Stack full: sixteen calls, then a seventeenth
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 1, 0, 8'(i * 8 + 3));
      check_outs($sformatf("fill%0d", i), 8'(i * 8 + 3), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1, 0, 1, 0, 8'hEE);
`ifdef STACK_GUARD_EN
    check_outs("overflow", 8'h7B, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1, 0, 0, 0, 8'h00);
    check_outs("fault hold inc", 8'h7B, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1, 0, 0, 1, 8'h00);
    check_outs("fault hold ret", 8'h7B, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    check_outs("overflow wrap", 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    check("overflow wdata", 32'(bus.stack_wdata), 32'h7C);
`endif

    // Return with an empty stack
    do_reset();
    step(1, 0, 0, 1, 8'h00);
`ifdef STACK_GUARD_EN
    check_outs("underflow", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1, 1, 0, 0, 8'h33);
    check_outs("underflow hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    check_outs("underflow wrap", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

    // Reset while a RETURN is in flight
    do_reset();
    step(1, 0, 1, 0, 8'h30);
    check_outs("midret call", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1, 0, 0, 1, 8'h00);
    check_outs("midret ret", 8'h30, 1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
    check_outs("midret reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midret wdata", 32'(bus.stack_wdata), 32'h0);
    step(1, 0, 0, 0, 8'h00);
    check_outs("midret after", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized run against the queue model; stimulus stays within stack bounds
    do_reset();
    m_pc = 8'h00;
    m_stk.delete();
    m_returning = 1'b0;
    m_ret_addr  = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      logic       e, j, c, r;
      logic [7:0] t;
      logic       x_push, x_pop, x_busy;
      logic [7:0] x_wdata;
      e = ($urandom_range(0, 3) != 0);
      j = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) == 0);
      t = 8'($urandom);
      if (!m_returning) begin
        if (m_stk.size() == 0) r = 1'b0;
        if (m_stk.size() >= 16) c = 1'b0;
      end
      x_push = 1'b0; x_pop = 1'b0; x_busy = 1'b0; x_wdata = 8'h00;
      if (m_returning) begin
        m_pc = m_ret_addr;
        m_returning = 1'b0;
      end else if (e) begin
        if (r) begin
          m_ret_addr  = m_stk.pop_back();
          m_returning = 1'b1;
          x_pop  = 1'b1;
          x_busy = 1'b1;
        end else if (c) begin
          x_push  = 1'b1;
          x_wdata = m_pc + 8'd1;
          m_stk.push_back(x_wdata);
          m_pc = t;
        end else if (j) begin
          m_pc = t;
        end else begin
          m_pc = m_pc + 8'd1;
        end
      end
      step(e, j, c, r, t);
      check_outs($sformatf("rnd%0d", n), m_pc, x_push, x_pop, x_busy, 1'b0);
      if (x_push)
        check($sformatf("rnd%0d wdata", n), 32'(bus.stack_wdata), 32'(x_wdata));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
